// File: rtl/pong_pkg.sv
// Shared constants for the pong datapath: state encodings, serve directions
// and default match settings reused by the ball block and the score display.
package pong_pkg;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SERVE_WAIT = 3'd1;
  localparam logic [2:0] PLAY       = 3'd2;
  localparam logic [2:0] POINT      = 3'd3;
  localparam logic [2:0] PAUSED     = 3'd4;
  localparam logic [2:0] GAME_OVER  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = IDLE,
    S_SERVE_WAIT = SERVE_WAIT,
    S_PLAY       = PLAY,
    S_POINT      = POINT,
    S_PAUSED     = PAUSED,
    S_GAME_OVER  = GAME_OVER
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int DEF_WIN_SCORE   = 7;
  localparam int DEF_SERVE_DELAY = 50;
  localparam int DEF_SCORE_W     = 4;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the match sequencer and the rest of the
// pong system. The master side is the sequencer itself.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic               pause;
  logic               miss_left;
  logic               miss_right;
  logic               ball_run;
  logic               ball_respawn;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    input  tick, start, pause, miss_left, miss_right,
    output ball_run, ball_respawn, serve_dir, score_left, score_right,
           game_over, winner, state
  );

  modport slave (
    output tick, start, pause, miss_left, miss_right,
    input  ball_run, ball_respawn, serve_dir, score_left, score_right,
           game_over, winner, state
  );
endinterface

// File: rtl/pong_btn_sync.sv
// Two-flop synchroniser for a raw button level with a one-clock rising-edge
// strobe taken from the synchronised value.
module pong_btn_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic sync_1, sync_2, prev;

  // Metastability chain plus the delayed copy used for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign level = sync_2;
  assign rise  = sync_2 & ~prev;

endmodule

// File: rtl/pong_game_ctrl.sv
// Match sequencer: serve / play / point / pause / game-over flow, both
// player scores, and the run/respawn gating of the ball and paddle logic.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input logic              clk,
  input logic              reset,
  pong_game_ctrl_if.master bus
);

  localparam int                 CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   DLY   = CNT_W'(SERVE_DELAY);

  logic start_lvl_unused, start_edge;
  logic pause_lvl, pause_rise_unused;

  pong_btn_sync u_start_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.start),
    .level (start_lvl_unused),
    .rise  (start_edge)
  );

  pong_btn_sync u_pause_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.pause),
    .level (pause_lvl),
    .rise  (pause_rise_unused)
  );

  state_e             state_q, state_d, saved_q, saved_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               dir_q, dir_d, winner_q, winner_d, respawn_q, respawn_d;

  // Scores stop at the winning value instead of wrapping
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN) ? WIN : s + 1'b1;
  endfunction

  // Match state and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      saved_q   <= S_IDLE;
      cnt_q     <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_q     <= DIR_RIGHT;
      winner_q  <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      saved_q   <= saved_d;
      cnt_q     <= cnt_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
      winner_q  <= winner_d;
      respawn_q <= respawn_d;
    end
  end

  // Next-state logic; pause is examined ahead of tick and miss handling
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    winner_d  = winner_q;
    respawn_d = 1'b0;
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_edge) begin
          score_l_d = '0;
          score_r_d = '0;
          dir_d     = DIR_RIGHT;
          winner_d  = 1'b0;
          respawn_d = 1'b1;
          cnt_d     = DLY;
          state_d   = S_SERVE_WAIT;
        end
      end
      S_SERVE_WAIT: begin
        if (pause_lvl) begin
          saved_d = S_SERVE_WAIT;
          state_d = S_PAUSED;
        end else if (bus.tick) begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (pause_lvl) begin
          saved_d = S_PLAY;
          state_d = S_PAUSED;
        end else if (bus.miss_left && bus.miss_right) begin
          state_d = S_POINT;
        end else if (bus.miss_left) begin
          score_r_d = sat_inc(score_r_q);
          dir_d     = DIR_LEFT;
          state_d   = S_POINT;
        end else if (bus.miss_right) begin
          score_l_d = sat_inc(score_l_q);
          dir_d     = DIR_RIGHT;
          state_d   = S_POINT;
        end
      end
      S_POINT: begin
        if (score_l_q == WIN || score_r_q == WIN) begin
          winner_d = (score_l_q == WIN);
          state_d  = S_GAME_OVER;
        end else begin
          cnt_d   = DLY;
          state_d = S_SERVE_WAIT;
        end
      end
      S_PAUSED: begin
        if (!pause_lvl) state_d = saved_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ball_run     = (state_q == S_PLAY);
  assign bus.ball_respawn = respawn_q | (state_q == S_POINT);
  assign bus.serve_dir    = dir_q;
  assign bus.score_left   = score_l_q;
  assign bus.score_right  = score_r_q;
  assign bus.game_over    = (state_q == S_GAME_OVER);
  assign bus.winner       = winner_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl with WIN_SCORE = 3 and SERVE_DELAY = 4.
// Expected point outcomes are queued when a miss is driven and compared when
// the controller enters POINT.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  localparam int WIN  = 3;
  localparam int SW   = 4;
  localparam int DLY  = 4;

  logic clk;
  logic rst_n;

  pong_game_ctrl_if #(.SCORE_W(SW)) bus ();

  pong_game_ctrl #(
    .WIN_SCORE   (WIN),
    .SCORE_W     (SW),
    .SERVE_DELAY (DLY)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    int sl;
    int sr;
    int dir;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp;
  int   n_bad;
  int   exp_l, exp_r, exp_dir;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cyc(1);
    bus.tick = 1'b0;
  endtask

  // Full serve: DLY ticks spaced 10 clk apart, PLAY only after the last one
  task automatic serve_full();
    for (int i = 1; i <= DLY; i++) begin
      cyc(9);
      tick_pulse();
      check_val("serve_state", int'(bus.state), (i == DLY) ? 2 : 1);
    end
  endtask

  task automatic miss(input logic l, input logic r);
    exp_t e;
    if (l && !r) begin
      exp_r   = (exp_r + 1 > WIN) ? WIN : exp_r + 1;
      exp_dir = 0;
    end else if (r && !l) begin
      exp_l   = (exp_l + 1 > WIN) ? WIN : exp_l + 1;
      exp_dir = 1;
    end
    e.sl = exp_l;
    e.sr = exp_r;
    e.dir = exp_dir;
    sb_q.push_back(e);
    bus.miss_left  = l;
    bus.miss_right = r;
    cyc(1);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  // Score monitor: every POINT cycle must match the oldest queued outcome
  always @(negedge clk) begin
    if (rst_n && bus.state == 3'd3) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected_point", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("sb_score_l", int'(bus.score_left), mon_e.sl);
        check_val("sb_score_r", int'(bus.score_right), mon_e.sr);
        check_val("sb_dir", int'(bus.serve_dir), mon_e.dir);
        check_val("sb_respawn", int'(bus.ball_respawn), 1);
        check_val("sb_ball_run", int'(bus.ball_run), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_l = 0;
    exp_r = 0;
    exp_dir = 1;
    rst_n = 1'b0;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;

    // Reset state
    cyc(3);
    check_val("rst_state", int'(bus.state), 0);
    check_val("rst_score_l", int'(bus.score_left), 0);
    check_val("rst_score_r", int'(bus.score_right), 0);
    check_val("rst_dir", int'(bus.serve_dir), 1);
    check_val("rst_ball_run", int'(bus.ball_run), 0);
    check_val("rst_respawn", int'(bus.ball_respawn), 0);
    check_val("rst_game_over", int'(bus.game_over), 0);
    rst_n = 1'b1;
    cyc(2);
    check_val("idle_state", int'(bus.state), 0);

    // Pause has no effect in IDLE
    bus.pause = 1'b1;
    cyc(5);
    check_val("idle_pause", int'(bus.state), 0);
    bus.pause = 1'b0;
    cyc(3);

    // Serve timing: respawn exactly 3 clk after start
    bus.start = 1'b1;
    cyc(2);
    check_val("start_respawn_early", int'(bus.ball_respawn), 0);
    check_val("start_state_early", int'(bus.state), 0);
    cyc(1);
    check_val("start_respawn", int'(bus.ball_respawn), 1);
    check_val("start_state", int'(bus.state), 1);
    cyc(1);
    check_val("start_respawn_1clk", int'(bus.ball_respawn), 0);
    bus.start = 1'b0;
    cyc(3);
    check_val("sw_ball_run", int'(bus.ball_run), 0);
    serve_full();
    check_val("play_ball_run", int'(bus.ball_run), 1);

    // Start during PLAY is ignored
    bus.start = 1'b1;
    cyc(5);
    bus.start = 1'b0;
    cyc(3);
    check_val("play_start_state", int'(bus.state), 2);
    check_val("play_start_respawn", int'(bus.ball_respawn), 0);

    // miss_left: right scores, serve toward left, then SERVE_WAIT
    miss(1'b1, 1'b0);
    check_val("point_state", int'(bus.state), 3);
    cyc(1);
    check_val("after_point_state", int'(bus.state), 1);
    check_val("after_point_respawn", int'(bus.ball_respawn), 0);

    // Simultaneous misses: no score change, direction kept
    serve_full();
    miss(1'b1, 1'b1);
    cyc(1);
    check_val("both_state", int'(bus.state), 1);

    // Pause in SERVE_WAIT with two ticks left
    cyc(9);
    tick_pulse();
    cyc(9);
    tick_pulse();
    bus.pause = 1'b1;
    cyc(3);
    check_val("pause_state", int'(bus.state), 4);
    for (int i = 0; i < 20; i++) begin
      tick_pulse();
      cyc(2);
      if (i == 10) begin
        bus.miss_left = 1'b1;
        cyc(1);
        bus.miss_left = 1'b0;
      end
    end
    check_val("paused_state", int'(bus.state), 4);
    check_val("paused_ball_run", int'(bus.ball_run), 0);
    check_val("paused_score_r", int'(bus.score_right), 1);
    bus.pause = 1'b0;
    cyc(3);
    check_val("unpause_state", int'(bus.state), 1);
    cyc(9);
    tick_pulse();
    check_val("unpause_tick1", int'(bus.state), 1);
    cyc(9);
    tick_pulse();
    check_val("unpause_tick2", int'(bus.state), 2);

    // Match end: left wins with three miss_right points
    miss(1'b0, 1'b1);
    cyc(1);
    serve_full();
    miss(1'b0, 1'b1);
    cyc(1);
    serve_full();
    miss(1'b0, 1'b1);
    cyc(1);
    check_val("go_state", int'(bus.state), 5);
    check_val("go_flag", int'(bus.game_over), 1);
    check_val("go_winner", int'(bus.winner), 1);
    check_val("go_score_l", int'(bus.score_left), 3);
    check_val("go_ball_run", int'(bus.ball_run), 0);
    bus.miss_left = 1'b1;
    cyc(1);
    bus.miss_left = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      cyc(3);
    end
    check_val("go_hold_state", int'(bus.state), 5);
    check_val("go_hold_score_l", int'(bus.score_left), 3);
    check_val("go_hold_score_r", int'(bus.score_right), 1);
    check_val("go_hold_winner", int'(bus.winner), 1);
    check_val("go_hold_respawn", int'(bus.ball_respawn), 0);

    // Restart from GAME_OVER
    bus.start = 1'b1;
    cyc(3);
    check_val("restart_state", int'(bus.state), 1);
    check_val("restart_respawn", int'(bus.ball_respawn), 1);
    check_val("restart_score_l", int'(bus.score_left), 0);
    check_val("restart_score_r", int'(bus.score_right), 0);
    check_val("restart_dir", int'(bus.serve_dir), 1);
    check_val("restart_game_over", int'(bus.game_over), 0);
    bus.start = 1'b0;
    cyc(3);
    exp_l = 0;
    exp_r = 0;
    exp_dir = 1;

    // Build 2/1 in PLAY, then reset asynchronously mid-cycle
    serve_full();
    miss(1'b0, 1'b1);
    cyc(1);
    serve_full();
    miss(1'b1, 1'b0);
    cyc(1);
    serve_full();
    miss(1'b0, 1'b1);
    cyc(1);
    serve_full();
    check_val("pre_rst_score_l", int'(bus.score_left), 2);
    check_val("pre_rst_score_r", int'(bus.score_right), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_state", int'(bus.state), 0);
    check_val("async_rst_score_l", int'(bus.score_left), 0);
    check_val("async_rst_score_r", int'(bus.score_right), 0);
    check_val("async_rst_dir", int'(bus.serve_dir), 1);
    check_val("async_rst_ball_run", int'(bus.ball_run), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    check_val("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
